// File: rtl/fifo_drain_arb_if.sv
// Handshake bundle between the drain arbiter, its four late-read source FIFOs and the sink.
// master = arbiter side, slave = source FIFOs / downstream sink side.
interface fifo_drain_arb_if #(
    parameter int DATAWIDTH = 18
);
    logic [3:0]             src_ne;
    logic [3:0]             src_re;
    logic [4*DATAWIDTH-1:0] src_rd_data;
    logic [3:0]             src_en;
    logic                   dst_full;
    logic                   out_valid;
    logic [DATAWIDTH-1:0]   out_data;
    logic [1:0]             out_src;
    logic                   busy;

    modport master (
        input  src_ne, src_rd_data, src_en, dst_full,
        output src_re, out_valid, out_data, out_src, busy
    );

    modport slave (
        output src_ne, src_rd_data, src_en, dst_full,
        input  src_re, out_valid, out_data, out_src, busy
    );
endinterface

// File: rtl/fifo_drain_arb.sv
// Round-robin burst drain of four late-read FIFOs into one registered word stream.
// Reads are issued combinationally; data returns one cycle later and leaves two cycles after the read.
module fifo_drain_arb #(
    parameter int DATAWIDTH = 18,
    parameter int BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    fifo_drain_arb_if.master bus
);
    localparam logic [3:0] BURST_LIMIT = 4'(BURST_MAX);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           cur_q, cur_d;
    logic [1:0]           last_q, last_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 rd_v_q, rd_v_d;
    logic [1:0]           rd_src_q, rd_src_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATAWIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]           out_src_q, out_src_d;

    logic [3:0]           eligible;
    logic [3:0]           re;
    logic [1:0]           grant_idx;
    logic [2:0]           pick;
    logic                 cont_ok;
    logic [DATAWIDTH-1:0] src_word [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
        assign src_word[gi] = bus.src_rd_data[gi*DATAWIDTH +: DATAWIDTH];
    end

    // Returns {found, index}: first eligible source after 'from', wrapping, 'from' itself last.
    function automatic logic [2:0] rr_pick(input logic [1:0] from, input logic [3:0] elig);
        logic [2:0] hit;
        logic [1:0] idx;
        hit = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = from + 2'(k);
            if (elig[idx]) hit = {1'b1, idx};
        end
        return hit;
    endfunction

    assign eligible = bus.src_ne & bus.src_en;
    assign pick     = rr_pick((state_q == IDLE) ? last_q : cur_q, eligible);
    assign cont_ok  = eligible[cur_q] && (cnt_q < BURST_LIMIT);

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        re        = 4'b0000;
        grant_idx = cur_q;
        if (!bus.dst_full) begin
            if (state_q == BURST && cont_ok) begin
                re[cur_q] = 1'b1;
                cnt_d     = cnt_q + 4'd1;
            end else if (pick[2]) begin
                // Fresh grant (from IDLE or end of burst) in the same cycle, so no bubble.
                grant_idx     = pick[1:0];
                re[pick[1:0]] = 1'b1;
                cur_d         = pick[1:0];
                last_d        = pick[1:0];
                cnt_d         = 4'd1;
                state_d       = BURST;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        rd_v_d      = |re;
        rd_src_d    = (|re) ? grant_idx : rd_src_q;
        out_valid_d = rd_v_q;
        out_data_d  = rd_v_q ? src_word[rd_src_q] : out_data_q;
        out_src_d   = rd_v_q ? rd_src_q : out_src_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= 2'd0;
            last_q      <= 2'd3;
            cnt_q       <= 4'd0;
            rd_v_q      <= 1'b0;
            rd_src_q    <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            rd_v_q      <= rd_v_d;
            rd_src_q    <= rd_src_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.src_re    = reset ? 4'b0000 : re;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.busy      = (state_q == BURST);
endmodule

// File: tb/tb_fifo_drain_arb.sv
// Scoreboard bench: instance 0 runs BURST_MAX=4, instance 1 runs BURST_MAX=2, each fed by a late-read FIFO model.
// Stimulus pushes expected words/grants into queues; per-instance monitors pop and compare on the falling edge.
module tb_fifo_drain_arb;
    localparam int DW = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic [3:0]    en_r [2];
    logic          full_r [2];
    logic [DW-1:0] mem [2][4][1024];
    int            wr_cnt [2][4];

    logic [DW-1:0] dexp_q [2][4][$];
    logic [1:0]    gexp_q [2][$];
    logic [1:0]    oexp_q [2][$];
    int            runmax [2];
    int            ovf_cnt [2];

    logic [1:0]    busy_w;
    logic [1:0]    ov_w;
    logic [7:0]    ne_w;
    logic [2*DW-1:0] od_w;
    logic [3:0]    os_w;
    logic [7:0]    re_w;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        fifo_drain_arb_if #(.DATAWIDTH(DW)) bus ();
        logic [DW-1:0] rdata [4];
        int            rd_ptr [4];
        int            re_cyc_q [$];
        logic [1:0]    re_src_q [$];
        int            run;
        int            c_pop;
        logic [1:0]    s_pop;
        logic [1:0]    idx;
        logic [DW-1:0] w_pop;

        fifo_drain_arb #(.DATAWIDTH(DW), .BURST_MAX(gi == 0 ? 4 : 2)) u_dut (
            .clk   (clk),
            .reset (rst),
            .bus   (bus.master)
        );

        for (genvar si = 0; si < 4; si++) begin : g_src
            assign bus.src_rd_data[si*DW +: DW] = rdata[si];
            assign bus.src_ne[si] = (rd_ptr[si] < wr_cnt[gi][si]);
            initial rd_ptr[si] = 0;
            // Late-read FIFO: word appears the cycle after its read enable.
            always @(posedge clk) begin
                if (bus.src_re[si]) begin
                    rdata[si]  <= mem[gi][si][rd_ptr[si]];
                    rd_ptr[si] <= rd_ptr[si] + 1;
                end
            end
        end

        assign bus.src_en       = en_r[gi];
        assign bus.dst_full     = full_r[gi];
        assign busy_w[gi]       = bus.busy;
        assign ov_w[gi]         = bus.out_valid;
        assign ne_w[gi*4 +: 4]  = bus.src_ne;
        assign od_w[gi*DW +: DW] = bus.out_data;
        assign os_w[gi*2 +: 2]  = bus.out_src;
        assign re_w[gi*4 +: 4]  = bus.src_re;

        initial run = 0;

        always @(negedge clk) begin
            if (rst) begin
                re_cyc_q.delete();
                re_src_q.delete();
                run = 0;
                chk(bus.src_re == 4'b0, "re_in_reset", 32'(bus.src_re), 0);
                chk(bus.out_valid == 1'b0, "ov_in_reset", 32'(bus.out_valid), 0);
            end else begin
                if (bus.src_re != 4'b0) begin
                    chk($onehot(bus.src_re), "re_onehot", 32'(bus.src_re), 1);
                    idx = 2'd0;
                    for (int b = 0; b < 4; b++) if (bus.src_re[b]) idx = 2'(b);
                    re_cyc_q.push_back(cyc);
                    re_src_q.push_back(idx);
                    if (gexp_q[gi].size() > 0) begin
                        s_pop = gexp_q[gi].pop_front();
                        chk(idx == s_pop, "grant_order", 32'(idx), 32'(s_pop));
                    end
                end
                if (full_r[gi]) begin
                    chk(bus.src_re == 4'b0, "re_while_full", 32'(bus.src_re), 0);
                    if (bus.out_valid) ovf_cnt[gi]++;
                end
                if (bus.out_valid) begin
                    $display("out inst=%0d src=%0d data=%05h cycle=%0d", gi, bus.out_src, bus.out_data, cyc);
                    run++;
                    if (run > runmax[gi]) runmax[gi] = run;
                    if (re_cyc_q.size() == 0) begin
                        chk(1'b0, "out_without_read", 32'(bus.out_src), 0);
                    end else begin
                        c_pop = re_cyc_q.pop_front();
                        s_pop = re_src_q.pop_front();
                        chk(cyc - c_pop == 2, "latency", 32'(cyc - c_pop), 2);
                        chk(bus.out_src == s_pop, "out_src_vs_read", 32'(bus.out_src), 32'(s_pop));
                    end
                    if (dexp_q[gi][bus.out_src].size() == 0) begin
                        chk(1'b0, "extra_word", 32'(bus.out_data), 0);
                    end else begin
                        w_pop = dexp_q[gi][bus.out_src].pop_front();
                        chk(bus.out_data == w_pop, "data", 32'(bus.out_data), 32'(w_pop));
                    end
                    if (oexp_q[gi].size() > 0) begin
                        s_pop = oexp_q[gi].pop_front();
                        chk(bus.out_src == s_pop, "out_order", 32'(bus.out_src), 32'(s_pop));
                    end
                end else begin
                    run = 0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int inst, input int s, input int n, input int tag);
        logic [3:0]    t4;
        logic [1:0]    s2;
        logic [11:0]   k12;
        logic [DW-1:0] w;
        for (int k = 0; k < n; k++) begin
            t4  = 4'(tag);
            s2  = 2'(s);
            k12 = 12'(wr_cnt[inst][s]);
            w   = {t4, s2, k12};
            mem[inst][s][wr_cnt[inst][s]] = w;
            dexp_q[inst][s].push_back(w);
            wr_cnt[inst][s]++;
        end
    endtask

    task automatic expect_grants(input int inst, input int s, input int n);
        for (int k = 0; k < n; k++) begin
            gexp_q[inst].push_back(2'(s));
            oexp_q[inst].push_back(2'(s));
        end
    endtask

    task automatic wait_drain(input int inst, input int limit);
        int  n;
        bit  done;
        done = 1'b0;
        for (n = 0; n < limit; n++) begin
            done = !busy_w[inst];
            for (int s = 0; s < 4; s++) if (dexp_q[inst][s].size() != 0) done = 1'b0;
            if (done) break;
            step(1);
        end
        chk(done, "drain_timeout", 32'(n), 32'(limit));
        step(2);
        chk(gexp_q[inst].size() == 0, "grants_left", 32'(gexp_q[inst].size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        en_r[0] = 4'hF; en_r[1] = 4'hF;
        full_r[0] = 1'b0; full_r[1] = 1'b0;
        runmax[0] = 0; runmax[1] = 0;
        ovf_cnt[0] = 0; ovf_cnt[1] = 0;
        rst = 1'b1;
        step(3);
        chk(ov_w == 2'b00, "rst_out_valid", 32'(ov_w), 0);
        chk(busy_w == 2'b00, "rst_busy", 32'(busy_w), 0);
        chk(od_w == '0, "rst_out_data", 32'(od_w[DW-1:0]), 0);
        chk(os_w == 4'b0, "rst_out_src", 32'(os_w), 0);
        chk(re_w == 8'b0, "rst_src_re", 32'(re_w), 0);
        rst = 1'b0;
        step(1);

        // Single source, 6 words, BURST_MAX=4: 4 reads then an immediate re-grant of the same source.
        runmax[0] = 0;
        load(0, 0, 6, 1);
        expect_grants(0, 0, 6);
        step(1);
        chk(busy_w[0] == 1'b1, "t1_busy", 32'(busy_w[0]), 1);
        wait_drain(0, 100);
        chk(runmax[0] == 6, "t1_contiguous", 32'(runmax[0]), 6);

        // Four sources of 8 words, BURST_MAX=2: pairs in strict round-robin, 32 words without a gap.
        runmax[1] = 0;
        for (int s = 0; s < 4; s++) load(1, s, 8, 2);
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < 4; s++) expect_grants(1, s, 2);
        wait_drain(1, 200);
        chk(runmax[1] == 32, "t2_contiguous", 32'(runmax[1]), 32);

        // dst_full for 5 cycles after the second read of src2; burst count must survive the stall.
        load(0, 2, 8, 3);
        load(0, 3, 4, 3);
        expect_grants(0, 2, 4);
        expect_grants(0, 3, 4);
        expect_grants(0, 2, 4);
        step(2);
        ovf_cnt[0] = 0;
        full_r[0] = 1'b1;
        step(5);
        chk(ovf_cnt[0] <= 2, "t3_inflight", 32'(ovf_cnt[0]), 2);
        chk(busy_w[0] == 1'b1, "t3_busy_hold", 32'(busy_w[0]), 1);
        full_r[0] = 1'b0;
        wait_drain(0, 100);

        // Only src2 enabled: src1 stays untouched, src2 drains and the arbiter idles.
        en_r[0] = 4'b0100;
        load(0, 1, 1, 4);
        load(0, 2, 3, 4);
        expect_grants(0, 2, 3);
        step(8);
        chk(busy_w[0] == 1'b0, "t4_idle", 32'(busy_w[0]), 0);
        chk(ne_w[1] == 1'b1, "t4_src1_unread", 32'(ne_w[1]), 1);
        chk(dexp_q[0][2].size() == 0, "t4_src2_done", 32'(dexp_q[0][2].size()), 0);
        chk(gexp_q[0].size() == 0, "t4_grants", 32'(gexp_q[0].size()), 0);
        expect_grants(0, 1, 1);
        en_r[0] = 4'hF;
        wait_drain(0, 100);

        // Reset the cycle after a src3 read: that word is lost and src1 wins first after release.
        load(0, 3, 3, 5);
        gexp_q[0].push_back(2'd3);
        step(1);
        rst = 1'b1;
        load(0, 1, 1, 5);
        step(3);
        void'(dexp_q[0][3].pop_front());
        expect_grants(0, 1, 1);
        expect_grants(0, 3, 2);
        rst = 1'b0;
        wait_drain(0, 100);
        chk(busy_w[0] == 1'b0, "t5_idle", 32'(busy_w[0]), 0);

        // Random traffic with random stalls and enables; per-source order checked by the monitor.
        for (int c = 0; c < 300; c++) begin
            for (int s = 0; s < 4; s++)
                if ($urandom_range(3) == 0) load(1, s, 1, 6);
            full_r[1] = ($urandom_range(4) == 0);
            if (c % 16 == 0) en_r[1] = 4'($urandom_range(15));
            step(1);
        end
        full_r[1] = 1'b0;
        en_r[1] = 4'hF;
        wait_drain(1, 2000);
        chk(ne_w[7:4] == 4'b0, "t6_all_read", 32'(ne_w[7:4]), 0);
        chk(ov_w == 2'b00, "end_quiet", 32'(ov_w), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
